// File: rtl/bit_serializer.sv
`timescale 1ns/1ps
// bit_serializer
//
// Shifts parallel words from the HPS/FIFO side out one bit at a time,
// together with a generated bit clock. Each bit occupies a low phase and
// then a high phase of the bit clock, each HALF_PERIOD iCLK cycles long.
// Data changes only on the falling edge of the bit clock, so a downstream
// deserializer can sample while the bit clock is high.
//
// Optional feature: define BIT_SERIALIZER_PARITY_EN to append one extra bit
// period carrying even parity (XOR of all data bits) after the last data
// bit. oCounter then runs to WORD_WIDTH+1.
//
// Ports:
//   iCLK      system clock, rising edge
//   iRST      asynchronous active-high reset
//   iData     word to transmit
//   iValid    iData valid
//   oReady    block can accept a word (IDLE)
//   iPause    freeze bit timing while high (SHIFT only)
//   oBit      serial data
//   oBIT_CLK  generated bit clock
//   oBusy     word transfer in progress
//   oDone     one-cycle pulse after the last bit
//   oCounter  number of bits fully sent in the current word
module bit_serializer #(
    parameter int unsigned WORD_WIDTH  = 32,
    parameter int unsigned HALF_PERIOD = 1,
    parameter bit          MSB_FIRST   = 1'b0,
`ifdef BIT_SERIALIZER_PARITY_EN
    localparam int unsigned TotalBits  = WORD_WIDTH + 1,
`else
    localparam int unsigned TotalBits  = WORD_WIDTH,
`endif
    localparam int unsigned CntWidth   = $clog2(TotalBits + 1)
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic [WORD_WIDTH-1:0] iData,
    input  logic                  iValid,
    output logic                  oReady,
    input  logic                  iPause,
    output logic                  oBit,
    output logic                  oBIT_CLK,
    output logic                  oBusy,
    output logic                  oDone,
    output logic [CntWidth-1:0]   oCounter
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} stateT;

    localparam logic [7:0]          PhaseLast = 8'(HALF_PERIOD - 1);
    localparam logic [CntWidth-1:0] CntLast   = CntWidth'(TotalBits - 1);

    stateT                 stateQ, stateD;
    logic [WORD_WIDTH-1:0] shiftQ, shiftD;
    logic [WORD_WIDTH-1:0] nextShift;
    logic [7:0]            phaseQ, phaseD;
    logic                  bitClkQ, bitClkD;
    logic                  bitQ, bitD;
    logic [CntWidth-1:0]   cntQ, cntD;
`ifdef BIT_SERIALIZER_PARITY_EN
    logic                  parityQ, parityD;
`endif

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            stateQ  <= StIdle;
            shiftQ  <= '0;
            phaseQ  <= '0;
            bitClkQ <= 1'b0;
            bitQ    <= 1'b0;
            cntQ    <= '0;
`ifdef BIT_SERIALIZER_PARITY_EN
            parityQ <= 1'b0;
`endif
        end else begin
            stateQ  <= stateD;
            shiftQ  <= shiftD;
            phaseQ  <= phaseD;
            bitClkQ <= bitClkD;
            bitQ    <= bitD;
            cntQ    <= cntD;
`ifdef BIT_SERIALIZER_PARITY_EN
            parityQ <= parityD;
`endif
        end
    end

    always_comb begin
        stateD    = stateQ;
        shiftD    = shiftQ;
        phaseD    = phaseQ;
        bitClkD   = bitClkQ;
        bitD      = bitQ;
        cntD      = cntQ;
        nextShift = MSB_FIRST ? (shiftQ << 1) : (shiftQ >> 1);
`ifdef BIT_SERIALIZER_PARITY_EN
        parityD   = parityQ;
`endif

        unique case (stateQ)
            StIdle: begin
                cntD    = '0;
                bitClkD = 1'b0;
                bitD    = 1'b0;
                phaseD  = '0;
                // oReady is high throughout IDLE, so iValid alone completes the handshake.
                if (iValid) begin
                    shiftD  = iData;
                    bitD    = MSB_FIRST ? iData[WORD_WIDTH-1] : iData[0];
                    stateD  = StShift;
`ifdef BIT_SERIALIZER_PARITY_EN
                    parityD = ^iData;
`endif
                end
            end

            StShift: begin
                // Pause freezes everything, including a phase that would end this cycle.
                if (!iPause) begin
                    if (phaseQ == PhaseLast) begin
                        phaseD = '0;
                        if (!bitClkQ) begin
                            bitClkD = 1'b1;
                        end else begin
                            // Falling edge: the bit just sent is complete.
                            bitClkD = 1'b0;
                            cntD    = cntQ + CntWidth'(1);
                            if (cntQ == CntLast) begin
                                stateD = StDone;
                                bitD   = 1'b0;
                            end else begin
                                shiftD = nextShift;
                                bitD   = MSB_FIRST ? nextShift[WORD_WIDTH-1] : nextShift[0];
`ifdef BIT_SERIALIZER_PARITY_EN
                                if (cntQ == CntWidth'(WORD_WIDTH - 1)) begin
                                    bitD = parityQ;
                                end
`endif
                            end
                        end
                    end else begin
                        phaseD = phaseQ + 8'd1;
                    end
                end
            end

            StDone: begin
                stateD  = StIdle;
                cntD    = '0;
                bitD    = 1'b0;
                bitClkD = 1'b0;
            end

            default: begin
                stateD = StIdle;
            end
        endcase
    end

    assign oReady   = (stateQ == StIdle);
    assign oBusy    = (stateQ == StShift);
    assign oDone    = (stateQ == StDone);
    assign oBit     = bitQ;
    assign oBIT_CLK = bitClkQ;
    assign oCounter = cntQ;

endmodule

// File: tb/tb_bit_serializer.sv
`timescale 1ns/1ps
// Bench for bit_serializer: two instances (HALF_PERIOD=1 LSB-first and
// HALF_PERIOD=3 MSB-first). A driver pushes every accepted word into a
// per-instance scoreboard; a negedge monitor pops it at the start of the
// transfer and checks every cycle against the expected bit sequence and
// bit-clock timing computed from the word with plain arithmetic.
module tb_bit_serializer;

    localparam int unsigned W = 32;
`ifdef BIT_SERIALIZER_PARITY_EN
    localparam int unsigned N = W + 1;
`else
    localparam int unsigned N = W;
`endif
    localparam int unsigned CW    = $clog2(N + 1);
    localparam int unsigned Limit = 5000;

    logic          clk;
    logic [1:0]    rst;
    logic [1:0]    valid;
    logic [1:0]    pause;
    logic [1:0]    dirP;
    logic [1:0]    randEn;
    logic [W-1:0]  data0, data1;
    logic [1:0]    rdy, sbit, bclk, busy, done;
    logic [CW-1:0] cnt0, cnt1;

    int nChk  = 0;
    int nFail = 0;

    // Scoreboard and monitor model state.
    logic [W-1:0] sbq0[$];
    logic [W-1:0] sbq1[$];
    bit           inX[2];
    bit           pend[2];
    int unsigned  act[2];
    logic [N-1:0] expSeq[2];

    bit_serializer #(.WORD_WIDTH(W), .HALF_PERIOD(1), .MSB_FIRST(1'b0)) dutA (
        .iCLK(clk), .iRST(rst[0]), .iData(data0), .iValid(valid[0]), .oReady(rdy[0]),
        .iPause(pause[0]), .oBit(sbit[0]), .oBIT_CLK(bclk[0]), .oBusy(busy[0]),
        .oDone(done[0]), .oCounter(cnt0)
    );

    bit_serializer #(.WORD_WIDTH(W), .HALF_PERIOD(3), .MSB_FIRST(1'b1)) dutB (
        .iCLK(clk), .iRST(rst[1]), .iData(data1), .iValid(valid[1]), .oReady(rdy[1]),
        .iPause(pause[1]), .oBit(sbit[1]), .oBIT_CLK(bclk[1]), .oBusy(busy[1]),
        .oDone(done[1]), .oCounter(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int unsigned hp(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // Transmitted bit order: k-th entry is the k-th bit on the wire.
    function automatic logic [N-1:0] seqOf(input logic [W-1:0] w, input bit msb);
        logic [N-1:0] s;
        s = '0;
        for (int k = 0; k < int'(W); k++) s[k] = msb ? w[W-1-k] : w[k];
`ifdef BIT_SERIALIZER_PARITY_EN
        s[N-1] = ^w;
`endif
        return s;
    endfunction

    task automatic chk(input string name, input int i, input logic [63:0] got,
                       input logic [63:0] exp);
        nChk++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s dut%0d @%0t: got %0h expected %0h", name, i, $time, got, exp);
        end
    endtask

    function automatic int sbSize(input int i);
        return (i == 0) ? sbq0.size() : sbq1.size();
    endfunction

    task automatic sbPush(input int i, input logic [W-1:0] w);
        if (i == 0) sbq0.push_back(w);
        else sbq1.push_back(w);
    endtask

    task automatic sbPop(input int i, output logic [W-1:0] w);
        w = '0;
        if (i == 0 && sbq0.size() > 0) w = sbq0.pop_front();
        if (i == 1 && sbq1.size() > 0) w = sbq1.pop_front();
    endtask

    task automatic sbFlush(input int i);
        if (i == 0) sbq0.delete();
        else sbq1.delete();
    endtask

    task automatic monStep(input int i, input logic r, input logic rdyv, input logic bitv,
                           input logic clkv, input logic busyv, input logic donev,
                           input logic [CW-1:0] cntv, input logic valv, input logic pauv);
        int unsigned  h;
        logic [W-1:0] w;
        h = hp(i);
        if (r) begin
            chk("rst_ready", i, rdyv, 1);
            chk("rst_bit", i, bitv, 0);
            chk("rst_bitclk", i, clkv, 0);
            chk("rst_busy", i, busyv, 0);
            chk("rst_done", i, donev, 0);
            chk("rst_counter", i, cntv, 0);
            inX[i]  = 1'b0;
            pend[i] = 1'b0;
            sbFlush(i);
        end else begin
            if (pend[i]) begin
                chk("sb_nonempty", i, sbSize(i) > 0, 1);
                sbPop(i, w);
                expSeq[i] = seqOf(w, i == 1);
                inX[i]    = 1'b1;
                act[i]    = 0;
                pend[i]   = 1'b0;
            end
            if (inX[i]) begin
                if (act[i] == 2 * h * N) begin
                    chk("done_pulse", i, donev, 1);
                    chk("done_busy", i, busyv, 0);
                    chk("done_ready", i, rdyv, 0);
                    chk("done_bitclk", i, clkv, 0);
                    chk("done_bit", i, bitv, 0);
                    chk("done_counter", i, cntv, N);
                    inX[i] = 1'b0;
                end else begin
                    chk("shift_done", i, donev, 0);
                    chk("shift_busy", i, busyv, 1);
                    chk("shift_ready", i, rdyv, 0);
                    chk("shift_bitclk", i, clkv, (act[i] / h) % 2);
                    chk("shift_bit", i, bitv, expSeq[i][act[i] / (2 * h)]);
                    chk("shift_counter", i, cntv, act[i] / (2 * h));
                    if (!pauv) act[i]++;
                end
            end else begin
                chk("idle_ready", i, rdyv, 1);
                chk("idle_busy", i, busyv, 0);
                chk("idle_done", i, donev, 0);
                chk("idle_bitclk", i, clkv, 0);
                chk("idle_bit", i, bitv, 0);
                chk("idle_counter", i, cntv, 0);
                if (valv) pend[i] = 1'b1;
            end
        end
    endtask

    always @(negedge clk) begin
        monStep(0, rst[0], rdy[0], sbit[0], bclk[0], busy[0], done[0], cnt0, valid[0], pause[0]);
        monStep(1, rst[1], rdy[1], sbit[1], bclk[1], busy[1], done[1], cnt1, valid[1], pause[1]);
    end

    // Sole driver of iPause: directed pulses plus optional random noise.
    always @(posedge clk) begin
        #2;
        pause[0] = dirP[0] | (randEn[0] & ($urandom_range(0, 7) == 0));
        pause[1] = dirP[1] | (randEn[1] & ($urandom_range(0, 7) == 0));
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic setData(input int i, input logic [W-1:0] w);
        if (i == 0) data0 = w;
        else data1 = w;
    endtask

    // Present a word and hold it until the handshake; entered and left at posedge+1.
    task automatic send(input int i, input logic [W-1:0] w, input bit hold);
        valid[i] = 1'b1;
        setData(i, w);
        for (int g = 0; g < int'(Limit); g++) begin
            @(negedge clk);
            if (rdy[i]) break;
        end
        chk("handshake", i, rdy[i], 1);
        sbPush(i, w);
        tick(1);
        if (!hold) begin
            valid[i] = 1'b0;
            setData(i, W'($urandom));
        end
    endtask

    task automatic waitIdle(input int i);
        for (int g = 0; g < int'(Limit); g++) begin
            @(negedge clk);
            if (!inX[i] && !pend[i]) break;
        end
        chk("xfer_timeout", i, inX[i] | pend[i], 0);
        tick(1);
    endtask

    task automatic waitCnt(input int i, input int unsigned t, input bit needHigh);
        logic [CW-1:0] c;
        c = '0;
        for (int g = 0; g < int'(Limit); g++) begin
            @(negedge clk);
            c = (i == 0) ? cnt0 : cnt1;
            if (c == CW'(t) && (!needHigh || bclk[i])) break;
        end
        chk("wait_counter", i, c, t);
        tick(1);
    endtask

    task automatic randomWords(input int i, input int n);
        bit hold;
        randEn[i] = 1'b1;
        for (int k = 0; k < n; k++) begin
            hold = ($urandom_range(0, 1) == 1) && (k != n - 1);
            send(i, W'($urandom), hold);
            if (!hold) tick($urandom_range(0, 3));
        end
        waitIdle(i);
        randEn[i] = 1'b0;
    endtask

    initial begin
        rst    = 2'b11;
        valid  = 2'b00;
        dirP   = 2'b00;
        randEn = 2'b00;
        pause  = 2'b00;
        data0  = '0;
        data1  = '0;
        tick(3);
        rst = 2'b00;
        tick(10);

        // Instance A: HALF_PERIOD=1, LSB first.
        send(0, 32'hA5A5_0F01, 1'b0);
        waitIdle(0);
        send(0, 32'h1234_5678, 1'b1);
        send(0, 32'hFEDC_BA98, 1'b0);
        waitIdle(0);
        send(0, 32'h0000_0007, 1'b0);
        waitIdle(0);
        send(0, 32'hDEAD_BEEF, 1'b0);
        waitCnt(0, 17, 1'b0);
        rst[0] = 1'b1;
        tick(1);
        rst[0] = 1'b0;
        tick(2);
        send(0, 32'h0F0F_3C3C, 1'b0);
        waitIdle(0);
        randomWords(0, 20);

        // Instance B: HALF_PERIOD=3, MSB first.
        send(1, 32'h8000_0001, 1'b0);
        waitIdle(1);
        send(1, 32'hC3C3_5A5A, 1'b0);
        waitCnt(1, 10, 1'b1);
        dirP[1] = 1'b1;
        tick(5);
        dirP[1] = 1'b0;
        waitIdle(1);
        randomWords(1, 8);

        tick(5);
        $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
        $finish;
    end

endmodule
